// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared state encoding and width helpers for the truth-table sweeper
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_t;

    // A vector index is N_IN bits, but never narrower than one bit.
    function automatic int idx_width(input int n_in);
        return (n_in < 1) ? 1 : n_in;
    endfunction

    // The settle counter only has to hold SETTLE-1, so clog2(SETTLE) bits are enough.
    function automatic int timer_width(input int settle);
        return (settle <= 1) ? 1 : $clog2(settle);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter with a zero flag
module settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - clocked exhaustive input sweep comparing two gate implementations
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [N_IN-1:0]      vec_out,
    output logic                 vec_valid,
    input  logic                 res_a,
    input  logic                 res_b,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_a,
    output logic [2**N_IN-1:0]   table_b,
    output logic [2**N_IN-1:0]   mismatch_map,
    output logic [N_IN:0]        mismatch_cnt,
    output logic                 equiv
);

    localparam int IW = idx_width(N_IN);
    localparam int TW = timer_width(SETTLE);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(SETTLE - 1);

    tt_state_t     state;
    tt_state_t     state_next;
    logic [IW-1:0] idx;
    logic          idx_last;
    logic          tmr_load;
    logic          tmr_dec;
    logic          tmr_zero;

    assign idx_last = (idx == {IW{1'b1}});

    settle_timer #(
        .W (TW)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (WAIT_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                    tmr_load   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_next = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (idx_last) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SETTLE;
                    tmr_load   = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // busy/done are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            vec_out      <= '0;
            vec_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_a      <= '0;
            table_b      <= '0;
            mismatch_map <= '0;
            mismatch_cnt <= '0;
            equiv        <= 1'b1;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_SETTLE) || (state_next == ST_SAMPLE);
            done  <= (state_next == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx          <= '0;
                        vec_out      <= '0;
                        vec_valid    <= 1'b1;
                        table_a      <= '0;
                        table_b      <= '0;
                        mismatch_map <= '0;
                        mismatch_cnt <= '0;
                        equiv        <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    table_a[idx]      <= res_a;
                    table_b[idx]      <= res_b;
                    mismatch_map[idx] <= res_a ^ res_b;
                    if (res_a != res_b) begin
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                        equiv        <= 1'b0;
                    end
                    if (idx_last) begin
                        vec_valid <= 1'b0;
                        vec_out   <= '0;
                    end else begin
                        idx     <= idx + 1'b1;
                        vec_out <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    localparam int S  = 1;
    localparam int S3 = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start3;
    logic [3:0] fa;
    logic [3:0] fb;

    logic [1:0] vec_out, vec_out3;
    logic       vec_valid, vec_valid3;
    logic       res_a, res_b, res_a3, res_b3;
    logic       busy, busy3, done, done3;
    logic [3:0] table_a, table_b, mismatch_map;
    logic [3:0] table_a3, table_b3, mismatch_map3;
    logic [2:0] mismatch_cnt, mismatch_cnt3;
    logic       equiv, equiv3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Each DUT is an arbitrary 2-input function given by its 4-entry truth table.
    assign res_a  = fa[vec_out];
    assign res_b  = fb[vec_out];
    assign res_a3 = fa[vec_out3];
    assign res_b3 = fb[vec_out3];

    truth_table_sweeper #(.N_IN(2), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vec_out(vec_out), .vec_valid(vec_valid),
        .res_a(res_a), .res_b(res_b),
        .busy(busy), .done(done),
        .table_a(table_a), .table_b(table_b),
        .mismatch_map(mismatch_map), .mismatch_cnt(mismatch_cnt), .equiv(equiv)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(S3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .vec_out(vec_out3), .vec_valid(vec_valid3),
        .res_a(res_a3), .res_b(res_b3),
        .busy(busy3), .done(done3),
        .table_a(table_a3), .table_b(table_b3),
        .mismatch_map(mismatch_map3), .mismatch_cnt(mismatch_cnt3), .equiv(equiv3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind 0: (~x)&y, kind 1: ~(x&y); x is the upper vector bit, y the lower.
    function automatic logic [3:0] gate_table(input int kind);
        logic [3:0] t;
        for (int i = 0; i < 4; i++) begin
            logic x, y;
            x = i[1];
            y = i[0];
            t[i] = (kind == 0) ? (~x & y) : ~(x & y);
        end
        return t;
    endfunction

    task automatic check_results(input string tag, input logic [3:0] a, input logic [3:0] b);
        check({tag, ".table_a"}, table_a, a);
        check({tag, ".table_b"}, table_b, b);
        check({tag, ".map"}, mismatch_map, a ^ b);
        check({tag, ".cnt"}, mismatch_cnt, $countones(a ^ b));
        check({tag, ".equiv"}, equiv, (a == b));
    endtask

    // One sweep on the SETTLE=1 instance; optional extra start pulse in cycle extra_start.
    task automatic run_sweep(input logic [3:0] a, input logic [3:0] b,
                             input int extra_start, input string tag);
        int done_cnt = 0;
        int done_cyc = 0;
        fa = a;
        fb = b;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c <= 8) begin
                check({tag, ".vec_out"}, vec_out, (c - 1) / (S + 1));
                check({tag, ".vec_valid"}, vec_valid, 1'b1);
                check({tag, ".busy"}, busy, 1'b1);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            start = (c == extra_start);
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".done_count"}, done_cnt, 1);
        check({tag, ".done_cycle"}, done_cyc, 9);
        check({tag, ".idle_busy"}, busy, 1'b0);
        check({tag, ".idle_valid"}, vec_valid, 1'b0);
        check_results(tag, a, b);
    endtask

    initial begin
        logic [3:0] ra, rb;
        int d1, d2, done_seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        fa     = 4'h0;
        fb     = 4'h0;
        repeat (3) @(negedge clk);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.valid", vec_valid, 1'b0);
        check("reset.vec_out", vec_out, 2'd0);
        check_results("reset", 4'h0, 4'h0);
        check("reset3.equiv", equiv3, 1'b1);
        rst_n = 1'b1;

        // Directed gate pairs: differing and identical implementations.
        run_sweep(gate_table(0), gate_table(1), 0, "nand_vs_andn");
        check("t1.table_a_lit", table_a, 4'b0010);
        check("t1.map_lit", mismatch_map, 4'b0101);
        run_sweep(gate_table(1), gate_table(1), 0, "nand_vs_nand");

        // Long settle trace on the second instance.
        fa = gate_table(0);
        fb = gate_table(1);
        @(negedge clk) start3 = 1'b1;
        @(posedge clk);
        @(negedge clk) start3 = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (c <= 16) begin
                check("s3.vec_out", vec_out3, (c - 1) / (S3 + 1));
                check("s3.vec_valid", vec_valid3, 1'b1);
                check("s3.busy", busy3, 1'b1);
                check("s3.done_low", done3, 1'b0);
            end else begin
                check("s3.done_high", done3, 1'b1);
                check("s3.table_a", table_a3, gate_table(0));
                check("s3.cnt", mismatch_cnt3, $countones(gate_table(0) ^ gate_table(1)));
            end
            @(negedge clk);
        end

        // Extra start pulse mid-sweep must be ignored.
        run_sweep(gate_table(0), gate_table(1), 4, "restart_ignored");

        // Reset in cycle 5 aborts the sweep without a done pulse.
        fa = 4'b1010;
        fb = 4'b0110;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort.busy", busy, 1'b0);
        check("abort.valid", vec_valid, 1'b0);
        check("abort.done", done, 1'b0);
        check_results("abort", 4'h0, 4'h0);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("abort.no_done", done_seen, 0);
        run_sweep(4'b1010, 4'b0110, 0, "after_abort");

        // Randomized function pairs against the table model.
        for (int r = 0; r < 6; r++) begin
            ra = 4'($urandom_range(0, 15));
            rb = (r == 2) ? ra : 4'($urandom_range(0, 15));
            run_sweep(ra, rb, 0, "random");
        end

        // Start held high: back-to-back sweeps with one IDLE cycle between.
        fa = gate_table(0);
        fb = gate_table(1);
        d1 = 0;
        d2 = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 19; c++) begin
            if (done === 1'b1) begin
                if (d1 == 0) d1 = c;
                else d2 = c;
            end
            if (c == 9) check_results("b2b.first", gate_table(0), gate_table(1));
            if (c == 10) check("b2b.idle_busy", busy, 1'b0);
            if (c == 11) check("b2b.restart_busy", busy, 1'b1);
            if (c == 19) begin
                check_results("b2b.second", gate_table(0), gate_table(1));
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b.done1", d1, 9);
        check("b2b.done2", d2, 19);
        repeat (3) @(negedge clk);
        check("b2b.stops", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
